sata_gen_negotiator: RTL and testbench

SATA_GEN_NEGOTIATOR -- requirements
Module: sata_gen_negotiator

---
 rtl/sata_gen_negotiator.sv | 140 ++++++++++++++
 tb/tb_sata_gen_negotiator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sata_gen_negotiator.sv
// SATA link-speed negotiator: walks generations MAX_GEN..1 through the transceiver
// reconfiguration interface, waiting a bounded time for link_up at each one.
module sata_gen_negotiator #(
    parameter int MAX_GEN      = 3,
    parameter int LOCK_TIMEOUT = 1000000,
    parameter int ROUNDS       = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       link_up,
    output logic       recfg_request,
    output logic [1:0] recfg_sata_gen,
    input  logic       recfg_ready,
    output logic [1:0] cur_gen,
    output logic       linked,
    output logic       fail,
    output logic       busy
);

    localparam int CNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int RND_W = $clog2(ROUNDS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS);
    localparam logic [RND_W-1:0] RND_ONE  = RND_W'(1);
    localparam logic [1:0]       GEN_MAX  = 2'(MAX_GEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GUARD,
        ST_WAIT_RDY,
        ST_WAIT_LINK,
        ST_LINKED,
        ST_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       gen_q, gen_d;
    logic [RND_W-1:0] round_q, round_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             req_q, req_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            gen_q   <= GEN_MAX;
            round_q <= '0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gen_q   <= gen_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gen_d   = gen_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        req_d   = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (start) begin
                    gen_d   = GEN_MAX;
                    round_d = RND_ONE;
                    state_d = ST_REQ;
                end
            end

            // The request pulse is registered, so it appears while in GUARD.
            ST_REQ: begin
                if (recfg_ready) begin
                    req_d   = 1'b1;
                    state_d = ST_GUARD;
                end
            end

            // Gives the interface one cycle to drop ready before it is polled.
            ST_GUARD: begin
                state_d = ST_WAIT_RDY;
            end

            ST_WAIT_RDY: begin
                if (recfg_ready) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_LINK;
                end
            end

            // link_up is tested first so it wins over a simultaneous timeout.
            ST_WAIT_LINK: begin
                if (link_up) begin
                    state_d = ST_LINKED;
                end else if (cnt_q == CNT_LAST) begin
                    if (gen_q > 2'd1) begin
                        gen_d   = gen_q - 2'd1;
                        state_d = ST_REQ;
                    end else if (round_q < RND_LAST) begin
                        gen_d   = GEN_MAX;
                        round_d = round_q + RND_ONE;
                        state_d = ST_REQ;
                    end else begin
                        state_d = ST_FAIL;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            // Start and a lost link both lead to the same single restart.
            ST_LINKED: begin
                if (start || !link_up) begin
                    gen_d   = GEN_MAX;
                    round_d = RND_ONE;
                    state_d = ST_REQ;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign recfg_request  = req_q;
    assign recfg_sata_gen = gen_q;
    assign linked         = (state_q == ST_LINKED);
    assign cur_gen        = linked ? gen_q : 2'd0;
    assign fail           = (state_q == ST_FAIL);
    assign busy           = (state_q == ST_REQ) || (state_q == ST_GUARD) ||
                            (state_q == ST_WAIT_RDY) || (state_q == ST_WAIT_LINK);

endmodule

// File: tb/tb_sata_gen_negotiator.sv
// Randomized scoreboard bench for sata_gen_negotiator: expected request generations
// are queued by a descent model and popped by a monitor on every request pulse.
module tb_sata_gen_negotiator;

    localparam int MG  = 3;
    localparam int LT  = 16;
    localparam int RND = 2;
    localparam int SPACING = LT + 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       link_up = 1'b0;
    logic       recfg_ready = 1'b1;
    logic       recfg_request;
    logic [1:0] recfg_sata_gen;
    logic [1:0] cur_gen;
    logic       linked;
    logic       fail;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    logic [3:0] link_mask = 4'b0000;
    int         link_delay = 5;
    bit         ready_rand = 1'b0;
    int         low_left = 0;

    sata_gen_negotiator #(
        .MAX_GEN     (MG),
        .LOCK_TIMEOUT(LT),
        .ROUNDS      (RND)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .link_up       (link_up),
        .recfg_request (recfg_request),
        .recfg_sata_gen(recfg_sata_gen),
        .recfg_ready   (recfg_ready),
        .cur_gen       (cur_gen),
        .linked        (linked),
        .fail          (fail),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference: try MAX_GEN..1 for each round; the first generation the link
    // partner answers at ends the negotiation, otherwise it fails (returns 0).
    function automatic int model_negotiate(input logic [3:0] mask);
        for (int r = 1; r <= RND; r++) begin
            for (int g = MG; g >= 1; g--) begin
                exp_q.push_back(g);
                if (mask[g]) return g;
            end
        end
        return 0;
    endfunction

    // Monitor: pops one expectation per request pulse and checks handshake/spacing.
    initial begin
        int  cyc;
        int  last_pulse;
        int  last_gen;
        int  g;
        bit  prev_ready;
        bit  prev_req;
        cyc = 0;
        last_pulse = -1;
        last_gen = 0;
        prev_ready = 1'b0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset) begin
                last_pulse = -1;
                prev_ready = 1'b0;
                prev_req = 1'b0;
            end else begin
                if (recfg_request) begin
                    check("req_after_ready_single", int'(prev_ready && !prev_req), 1);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_request gen=%0d required=none", recfg_sata_gen);
                    end else begin
                        g = exp_q.pop_front();
                        check("request_gen", int'(recfg_sata_gen), g);
                    end
                    if (last_pulse >= 0 && !link_mask[last_gen]) begin
                        if (ready_rand)
                            check("request_spacing_min", int'((cyc - last_pulse) >= SPACING), 1);
                        else
                            check("request_spacing", cyc - last_pulse, SPACING);
                    end
                    last_pulse = cyc;
                    last_gen = int'(recfg_sata_gen);
                end
                prev_ready = recfg_ready;
                prev_req = recfg_request;
            end
        end
    end

    // Reconfiguration interface: always ready, or ready with random stalls of 1..12 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (low_left > 0) begin
                recfg_ready = 1'b0;
                low_left--;
            end else if (ready_rand && $urandom_range(0, 5) == 0) begin
                low_left = $urandom_range(0, 11);
                recfg_ready = 1'b0;
            end else begin
                recfg_ready = 1'b1;
            end
        end
    end

    // Link partner: answers link_delay cycles after a request at a generation it supports.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && recfg_request && link_mask[recfg_sata_gen]) begin
                repeat (link_delay) @(posedge clk);
                #1 link_up = 1'b1;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        start = 1'b0;
        link_up = 1'b0;
        #1;
        check("reset_outputs", int'({recfg_request, recfg_sata_gen, cur_gen, linked, fail, busy}),
              int'({1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 1'b0}));
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (linked || fail) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout linked=%0d fail=%0d required=done", name, linked, fail);
        end
    endtask

    task automatic check_result(input string name, input int exp_gen);
        check({name, "_linked"}, int'(linked), int'(exp_gen != 0));
        check({name, "_cur_gen"}, int'(cur_gen), exp_gen);
        check({name, "_fail"}, int'(fail), int'(exp_gen == 0));
        check({name, "_busy"}, int'(busy), 0);
        check({name, "_pending"}, exp_q.size(), 0);
        if (exp_gen == 0) begin
            check({name, "_fail_gen"}, int'(recfg_sata_gen), 1);
            repeat (40) @(negedge clk);
            check({name, "_fail_hold"}, int'({fail, busy}), 2);
        end
    endtask

    task automatic run_case(input string name, input logic [3:0] mask, input int delay,
                            input bit rr, input bit mid_start, input bit drop, input bit drop_start);
        int exp_gen;
        do_reset();
        link_mask = mask;
        link_delay = delay;
        ready_rand = rr;
        exp_gen = model_negotiate(mask);
        pulse_start();
        if (mid_start) begin
            repeat ($urandom_range(3, 20)) @(negedge clk);
            if (busy) begin
                start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        wait_done(name);
        check_result(name, exp_gen);
        if (exp_gen != 0 && drop) begin
            repeat ($urandom_range(1, 5)) @(posedge clk);
            void'(model_negotiate(mask));
            #1;
            link_up = 1'b0;
            start = drop_start;
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            check({name, "_drop_state"}, int'({linked, cur_gen, busy}), int'({1'b0, 2'd0, 1'b1}));
            wait_done({name, "_relink"});
            check_result({name, "_relink"}, exp_gen);
        end
    endtask

    initial begin
        #200_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        run_case("gen3_first", 4'b1000, 7, 1'b0, 1'b0, 1'b0, 1'b0);
        run_case("gen1_only_tie", 4'b0010, 17, 1'b0, 1'b0, 1'b0, 1'b0);
        run_case("no_link_fail", 4'b0000, 5, 1'b0, 1'b0, 1'b0, 1'b0);
        run_case("gen2_drop", 4'b0100, 2, 1'b0, 1'b1, 1'b1, 1'b0);
        run_case("gen2_drop_start", 4'b0100, 9, 1'b0, 1'b0, 1'b1, 1'b1);
        run_case("stall_fail", 4'b0000, 4, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int t = 0; t < 12; t++) begin
            run_case($sformatf("rand%0d", t), {3'($urandom_range(0, 7)), 1'b0},
                     $urandom_range(2, 17), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset while waiting for link at gen 2 aborts and stays idle.
        do_reset();
        link_mask = 4'b0000;
        ready_rand = 1'b0;
        void'(model_negotiate(4'b0000));
        pulse_start();
        g = 0;
        for (int i = 0; i < 200 && g < 2; i++) begin
            @(negedge clk);
            if (recfg_request) g++;
        end
        check("reset_mid_reached_gen2", g, 2);
        repeat (3) @(posedge clk);
        do_reset();
        repeat (40) @(negedge clk);
        check("reset_mid_idle", int'({busy, linked, fail, recfg_sata_gen}), int'({3'b000, 2'd3}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
